// File: rtl/spike_aer_encoder_pkg.sv
// Shared types and helpers for the spike AER encoder: state encoding, neuron count,
// address width and the lowest-set-bit / single-bit helpers.
package spike_aer_encoder_pkg;

  localparam int NEURONS = 16;
  localparam int ADDR_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_e;

  function automatic logic [ADDR_W-1:0] lowest_set(input logic [NEURONS-1:0] m);
    lowest_set = '0;
    for (int i = NEURONS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = ADDR_W'(i);
    end
  endfunction

  function automatic logic is_onehot(input logic [NEURONS-1:0] m);
    return (m != '0) && ((m & (m - NEURONS'(1))) == '0);
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// Mask-word FIFO: writes on push, exposes head from the register array, pop advances.
// A push while full is taken only when a pop happens on the same edge.
module spike_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  // When full, the slot being written is the one being read out this same edge.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Captures fired-neuron masks on REQ into a FIFO and serialises each into AER events,
// lowest neuron first. Outputs are registered; back-to-back masks emit without a bubble.
module spike_aer_encoder
  import spike_aer_encoder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
) (
  input  logic                CLK,
  input  logic                RSTB,
  input  logic                REQ,
  input  logic [NEURONS-1:0]  NEURON_OUT,
  input  logic [TS_W-1:0]     TS,
  input  logic                OVF_CLR,
  output logic                AER_VALID,
  input  logic                AER_READY,
  output logic [ADDR_W-1:0]   AER_ADDR,
  output logic [TS_W-1:0]     AER_TS,
  output logic                AER_LAST,
  output logic                OVF,
  output logic                EMPTY
);

  localparam int W     = TS_W + NEURONS;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  enc_state_e         state, state_nxt;
  logic [NEURONS-1:0] wm, wm_nxt, wm_clr;
  logic [TS_W-1:0]    wts, wts_nxt;
  logic               push_req, pop, drop;
  logic [W-1:0]       head;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  assign push_req = REQ && (NEURON_OUT != '0);
  assign drop     = push_req && fifo_full && !pop;
  assign wm_clr   = wm & (wm - NEURONS'(1));
  assign EMPTY    = (fifo_count == '0) && (state == IDLE);

  spike_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RSTB),
    .push  (push_req),
    .din   ({TS, NEURON_OUT}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    wm_nxt    = wm;
    wts_nxt   = wts;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          wm_nxt    = head[NEURONS-1:0];
          wts_nxt   = head[W-1:NEURONS];
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (AER_READY) begin
          if (wm_clr != '0) begin
            wm_nxt = wm_clr;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            wm_nxt  = head[NEURONS-1:0];
            wts_nxt = head[W-1:NEURONS];
          end else begin
            wm_nxt    = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Event fields are computed from the next working mask so they leave flops directly.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state     <= IDLE;
      wm        <= '0;
      wts       <= '0;
      AER_VALID <= 1'b0;
      AER_ADDR  <= '0;
      AER_TS    <= '0;
      AER_LAST  <= 1'b0;
      OVF       <= 1'b0;
    end else begin
      state     <= state_nxt;
      wm        <= wm_nxt;
      wts       <= wts_nxt;
      AER_VALID <= (state_nxt == EMIT);
      AER_ADDR  <= lowest_set(wm_nxt);
      AER_TS    <= wts_nxt;
      AER_LAST  <= is_onehot(wm_nxt);
      if (drop)         OVF <= 1'b1;
      else if (OVF_CLR) OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Randomised and directed bench for spike_aer_encoder against a queue-based event model.
`timescale 1ns/1ps
module tb_spike_aer_encoder;

  localparam int DEPTH = 8;
  localparam int TS_W  = 8;

  logic            CLK, RSTB, REQ, OVF_CLR, AER_READY;
  logic [15:0]     NEURON_OUT;
  logic [TS_W-1:0] TS;
  logic            AER_VALID, AER_LAST, OVF, EMPTY;
  logic [3:0]      AER_ADDR;
  logic [TS_W-1:0] AER_TS;

  int vectors = 0;
  int miscompares = 0;

  spike_aer_encoder #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .CLK(CLK), .RSTB(RSTB), .REQ(REQ), .NEURON_OUT(NEURON_OUT), .TS(TS),
    .OVF_CLR(OVF_CLR), .AER_VALID(AER_VALID), .AER_READY(AER_READY),
    .AER_ADDR(AER_ADDR), .AER_TS(AER_TS), .AER_LAST(AER_LAST),
    .OVF(OVF), .EMPTY(EMPTY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: queued words, the mask currently being emitted, sticky overflow.
  typedef struct packed { logic [TS_W-1:0] ts; logic [15:0] m; } word_t;
  word_t           q[$];
  logic [15:0]     cur;
  logic [TS_W-1:0] cur_ts;
  bit              busy, m_ovf;

  function automatic int low_idx(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  always @(posedge CLK or negedge RSTB) begin : model
    int    qn;
    bit    do_pop;
    word_t w;
    if (!RSTB) begin
      q.delete();
      cur = '0; cur_ts = '0; busy = 0; m_ovf = 0;
    end else begin
      qn = q.size();
      do_pop = 0;
      if (busy) begin
        if (AER_READY) begin
          cur[low_idx(cur)] = 1'b0;
          if (cur == '0) begin
            if (qn > 0) do_pop = 1;
            else busy = 0;
          end
        end
      end else if (qn > 0) begin
        do_pop = 1;
      end
      if (do_pop) begin
        w = q.pop_front();
        cur = w.m; cur_ts = w.ts; busy = 1;
      end
      if (REQ && NEURON_OUT != '0 && !(qn < DEPTH || do_pop)) m_ovf = 1;
      else if (OVF_CLR) m_ovf = 0;
      if (REQ && NEURON_OUT != '0 && (qn < DEPTH || do_pop)) q.push_back({TS, NEURON_OUT});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_outputs();
    chk("valid", 32'(AER_VALID), 32'(busy));
    chk("empty", 32'(EMPTY), 32'(q.size() == 0 && !busy));
    chk("ovf",   32'(OVF),   32'(m_ovf));
    if (busy) begin
      chk("addr", 32'(AER_ADDR), 32'(low_idx(cur)));
      chk("ts",   32'(AER_TS),   32'(cur_ts));
      chk("last", 32'(AER_LAST), 32'($countones(cur) == 1));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic drive_req(input logic [15:0] m, input logic [TS_W-1:0] t);
    REQ = 1'b1; NEURON_OUT = m; TS = t;
  endtask

  task automatic drain(input int budget);
    REQ = 1'b0; AER_READY = 1'b1; OVF_CLR = 1'b0;
    for (int i = 0; i < budget && !EMPTY; i++) tick();
    chk("drain_done", 32'(EMPTY), 32'd1);
  endtask

  initial begin
    RSTB = 1'b0; REQ = 1'b0; NEURON_OUT = '0; TS = '0; OVF_CLR = 1'b0; AER_READY = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_valid", 32'(AER_VALID), 32'd0);
    chk("rst_addr",  32'(AER_ADDR),  32'd0);
    chk("rst_ts",    32'(AER_TS),    32'd0);
    chk("rst_last",  32'(AER_LAST),  32'd0);
    chk("rst_ovf",   32'(OVF),       32'd0);
    chk("rst_empty", 32'(EMPTY),     32'd1);
    RSTB = 1'b1;
    tick();

    // Single mask 8005 at ts 3: events 0, 2, 15 with 2-edge latency.
    AER_READY = 1'b1;
    drive_req(16'h8005, 8'd3);
    tick();
    REQ = 1'b0;
    chk("t1_lat_e0", 32'(AER_VALID), 32'd0);
    tick();
    chk("t1_ev0_vld", 32'(AER_VALID), 32'd1);
    chk("t1_ev0_addr", 32'(AER_ADDR), 32'd0);
    tick();
    chk("t1_ev1_addr", 32'(AER_ADDR), 32'd2);
    chk("t1_ev1_last", 32'(AER_LAST), 32'd0);
    tick();
    chk("t1_ev2_addr", 32'(AER_ADDR), 32'd15);
    chk("t1_ev2_last", 32'(AER_LAST), 32'd1);
    chk("t1_ev2_ts",   32'(AER_TS),   32'd3);
    tick();
    chk("t1_empty", 32'(EMPTY), 32'd1);

    // Backpressure on mask 0003.
    AER_READY = 1'b0;
    drive_req(16'h0003, 8'd7);
    tick();
    REQ = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_stall_addr", 32'(AER_ADDR), 32'd0);
      chk("t2_stall_vld",  32'(AER_VALID), 32'd1);
    end
    AER_READY = 1'b1;
    tick();
    chk("t2_addr1", 32'(AER_ADDR), 32'd1);
    chk("t2_last1", 32'(AER_LAST), 32'd1);
    tick();
    chk("t2_idle", 32'(EMPTY), 32'd1);

    // Zero mask is ignored.
    drive_req(16'h0000, 8'd9);
    tick();
    REQ = 1'b0;
    chk("t3_empty", 32'(EMPTY), 32'd1);
    chk("t3_ovf",   32'(OVF),   32'd0);
    tick();

    // Overflow: encoder holds one, FIFO holds DEPTH, the next drops.
    AER_READY = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive_req(16'hFFFF, TS_W'(i));
      tick();
    end
    chk("t4_no_ovf", 32'(OVF), 32'd0);
    drive_req(16'hFFFF, 8'd20);
    tick();
    chk("t4_ovf_set", 32'(OVF), 32'd1);
    OVF_CLR = 1'b1;
    tick();
    chk("t4_set_wins", 32'(OVF), 32'd1);
    REQ = 1'b0;
    tick();
    chk("t4_cleared", 32'(OVF), 32'd0);
    OVF_CLR = 1'b0;
    drain(400);

    // Back-to-back single-bit masks.
    drive_req(16'h0001, 8'd1);
    tick();
    drive_req(16'h0002, 8'd2);
    tick();
    REQ = 1'b0;
    chk("t5_a_addr", 32'(AER_ADDR), 32'd0);
    chk("t5_a_ts",   32'(AER_TS),   32'd1);
    tick();
    chk("t5_b_vld",  32'(AER_VALID), 32'd1);
    chk("t5_b_addr", 32'(AER_ADDR),  32'd1);
    chk("t5_b_ts",   32'(AER_TS),    32'd2);
    chk("t5_b_last", 32'(AER_LAST),  32'd1);
    tick();
    chk("t5_empty", 32'(EMPTY), 32'd1);

    // Reset while emitting with 3 words queued.
    AER_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(16'h0F0F, TS_W'(i + 5));
      tick();
    end
    REQ = 1'b0;
    tick();
    chk("t6_pre_vld", 32'(AER_VALID), 32'd1);
    #2 RSTB = 1'b0;
    #1;
    chk("t6_rst_vld",   32'(AER_VALID), 32'd0);
    chk("t6_rst_addr",  32'(AER_ADDR),  32'd0);
    chk("t6_rst_ts",    32'(AER_TS),    32'd0);
    chk("t6_rst_last",  32'(AER_LAST),  32'd0);
    chk("t6_rst_empty", 32'(EMPTY),     32'd1);
    @(negedge CLK);
    RSTB = 1'b1;
    AER_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_no_event", 32'(AER_VALID), 32'd0);
    end

    // Random traffic with random backpressure and clears.
    for (int i = 0; i < 3000; i++) begin
      REQ = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       NEURON_OUT = 16'h0000;
        1:       NEURON_OUT = 16'h0001 << $urandom_range(0, 15);
        2:       NEURON_OUT = 16'($urandom) & 16'($urandom);
        default: NEURON_OUT = 16'($urandom);
      endcase
      TS        = TS_W'($urandom);
      AER_READY = ((i / 200) % 2 == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      OVF_CLR   = ($urandom_range(0, 19) == 0);
      tick();
    end
    drain(DEPTH * 16 * 2 + 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spike_aer_encoder.md
# spike_aer_encoder

Downstream stage of the CIM macro's neuron output. Whenever the macro's `REQ` pulses, the block captures the 16-bit fired-neuron mask together with a time-step tag and queues it in a small FIFO. It then serialises each queued mask into address-event (AER) words, one per fired neuron, in ascending neuron order, over a valid/ready handshake to the chip output or the next layer.

## Interface

Parameters
- `DEPTH`, default 8: FIFO depth in mask words. Must be a power of 2 and at least 2.
- `TS_W`, default 8: width of the time-step tag.

Ports
- `CLK`, input, 1: clock.
- `RSTB`, input, 1: reset. Asynchronous, active-low. One clock; all state is reset asynchronously.
- `REQ`, input, 1: neuron output request from the CIM macro. Synchronous to `CLK`.
- `NEURON_OUT`, input, 16: fired mask. Valid in any cycle where `REQ`=1.
- `TS`, input, `TS_W`: current time-step index. Sampled together with the mask.
- `OVF_CLR`, input, 1: synchronous clear of `OVF`.
- `AER_VALID`, output, 1: event valid.
- `AER_READY`, input, 1: consumer ready.
- `AER_ADDR`, output, 4: fired neuron index, 0 to 15.
- `AER_TS`, output, `TS_W`: time-step tag of the event.
- `AER_LAST`, output, 1: event is the last one of its mask.
- `OVF`, output, 1: sticky flag, set when a non-zero mask is dropped because the FIFO is full.
- `EMPTY`, output, 1: FIFO is empty and the encoder holds no pending bits.

## Operation

Reset values
- `AER_VALID`, `AER_ADDR`, `AER_TS`, `AER_LAST`, `OVF` all reset to 0.
- `EMPTY` resets to 1.
- FIFO pointers and count reset to 0. Working mask resets to 0.

Capture
- On a rising edge with `REQ`=1 and `NEURON_OUT`≠0, push `{TS, NEURON_OUT}`.
- A zero mask is never pushed and never sets `OVF`.
- A push is accepted when `count` < `DEPTH`, or when a pop occurs on the same edge.
- Otherwise the word is dropped and `OVF` is set.
- `OVF_CLR` clears `OVF`. If clear and set coincide on the same edge, set wins.

Encoder state machine
- States: `IDLE` and `EMIT`.
- `IDLE`: when the FIFO is non-empty, pop the head into the working mask `wm` and `wts`, then go to `EMIT`.
- `EMIT`:
  - `AER_VALID`=1.
  - `AER_ADDR` = index of the lowest set bit of `wm`.
  - `AER_TS` = `wts`.
  - `AER_LAST` = 1 when `wm` has exactly one bit set.
- On an `EMIT` edge with `AER_READY`=1:
  - Clear that bit of `wm`.
  - If it was the last bit and the FIFO is non-empty, pop the next word on the same edge and stay in `EMIT`. This gives back-to-back events with no bubble.
  - If it was the last bit and the FIFO is empty, go to `IDLE`.
- If `AER_READY`=0, all AER outputs hold stable. `AER_VALID` is never withdrawn without a handshake.

Other rules
- `EMPTY` = (`count`==0) and (state==`IDLE`).
- Pointers wrap modulo `DEPTH`. `count` ranges from 0 to `DEPTH`.
- Reset mid-operation discards all queued words and the current mask without emitting anything further.

## Timing

- Push on edge E0 (`REQ` high). In `IDLE`, the pop occurs at E1, and `AER_VALID` rises after E1. Latency is therefore 2 edges from the `REQ` edge to the first valid event.
- Throughput: one event per cycle while `AER_READY`=1, including across mask boundaries.
- Simultaneous push and pop when `count`==`DEPTH`: the push is accepted and `count` stays at `DEPTH`.
- `REQ` may assert on consecutive cycles. Each cycle is an independent push.
- All outputs are registered. There is no combinational path from `AER_READY` to any output.

## Structure

- Shared package:
  - the `IDLE`/`EMIT` state encoding;
  - `NEURONS`=16;
  - the address width of 4.
- Sub-module `spike_fifo`: a synchronous FIFO with parameters width = `TS_W`+16 and depth `DEPTH`. It provides `push`, `pop`, `full`, `empty` and `count`, and has a registered read head.
- The top level holds the capture logic, the encoder FSM, a priority encoder (lowest set bit) and the `OVF` logic.

## Test plan

1. Reset, then a single push: `REQ`=1, `NEURON_OUT`=16'h8005, `TS`=3, with `AER_READY` held at 1.
   - Expect events at addresses 0, 2, 15, all with `AER_TS`=3.
   - `AER_LAST` is high only on address 15.
   - The first `AER_VALID` appears 2 edges after the push.
   - Afterwards `EMPTY`=1.
2. Backpressure: push 16'h0003. Hold `AER_READY`=0 for 5 cycles, then release.
   - `AER_ADDR`=0 is held stable throughout the stall.
   - After release, address 1 follows, then the block returns to `IDLE`.
3. Zero mask: `REQ`=1 with `NEURON_OUT`=0.
   - No push, `EMPTY` stays 1, `OVF` stays 0.
4. Overflow: with `AER_READY`=0, push 9 masks of 16'hFFFF (`DEPTH`=8).
   - The encoder holds one word and the FIFO holds 8, so no overflow yet.
   - A 10th push sets `OVF`=1.
   - `OVF_CLR` clears it, except on an edge with a simultaneous drop, where `OVF` stays 1.
5. Back-to-back masks: push 16'h0001 at `TS`=1 and 16'h0002 at `TS`=2 on consecutive cycles, with `AER_READY`=1.
   - Expect address 0 (ts 1) and then address 1 (ts 2) on consecutive cycles with no bubble. Both have `AER_LAST`=1.
6. Reset mid-emit: assert `RSTB` low while in `EMIT` with 3 words queued.
   - All outputs go to their reset values immediately.
   - No event is emitted after `RSTB` is released.
